mempool_dma_bank_splitter: RTL and testbench

- Tile-side stage directly downstream of the DMA's wide TCDM request (`tcdm_dma_req_t`, `DmaNumWords` × 32-bit words).
- Splits one wide superbank access into `NumWords` independent per-bank word requests, each with its own valid/ready handshake.
- For reads, collects the per-bank read data, which may return out of order, and re-assembles it into one wide response.
- Supports one outstanding wide transaction at a time.

---
 rtl/mempool_dma_bank_splitter.sv | 160 ++++++++++++++++
 tb/tb_mempool_dma_bank_splitter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mempool_dma_bank_splitter.sv
// Splits one wide DMA superbank access into per-bank word requests and
// re-assembles out-of-order read data. Optional: MEMPOOL_DMA_SPLIT_STALL_CNT_EN.
module mempool_dma_bank_splitter #(
  parameter int unsigned NumWords  = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_wen_i,
  input  logic [AddrWidth-1:0]            req_addr_i,
  input  logic [NumWords*DataWidth-1:0]   req_wdata_i,
  input  logic [NumWords*DataWidth/8-1:0] req_be_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [NumWords*DataWidth-1:0]   resp_rdata_o,
  output logic [NumWords-1:0]             bank_req_valid_o,
  input  logic [NumWords-1:0]             bank_req_ready_i,
  output logic [NumWords*AddrWidth-1:0]   bank_addr_o,
  output logic [NumWords-1:0]             bank_wen_o,
  output logic [NumWords*DataWidth-1:0]   bank_wdata_o,
  output logic [NumWords*DataWidth/8-1:0] bank_be_o,
  input  logic [NumWords-1:0]             bank_resp_valid_i,
  input  logic [NumWords*DataWidth-1:0]   bank_rdata_i,
  output logic [31:0]                     stall_cycles_o
);

  localparam int unsigned BeWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e                          state_q, state_d;
  logic                            wen_q, wen_d;
  logic [AddrWidth-1:0]            addr_q, addr_d;
  logic [NumWords*DataWidth-1:0]   wdata_q, wdata_d;
  logic [NumWords*BeWidth-1:0]     be_q, be_d;
  logic [NumWords-1:0]             pending_q, pending_d;
  logic [NumWords-1:0]             got_q, got_d;
  logic [NumWords*DataWidth-1:0]   rdata_q, rdata_d;
  logic [NumWords-1:0]             rsp_hit;

  // Next-state logic: latch request, track bank accepts and returned words.
  always_comb begin
    state_d   = state_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    pending_d = pending_q;
    got_d     = got_q;
    rdata_d   = rdata_q;
    rsp_hit   = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          wen_d   = req_wen_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
          for (int i = 0; i < NumWords; i++) begin
            pending_d[i] = req_wen_i ?
              |req_be_i[i*BeWidth +: BeWidth] : 1'b1;
          end
          got_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        pending_d = pending_q & ~bank_req_ready_i;
        if (!wen_q) begin
          // Duplicate responses for an already-filled word are dropped.
          rsp_hit = bank_resp_valid_i & ~got_q;
          for (int i = 0; i < NumWords; i++) begin
            if (rsp_hit[i]) begin
              rdata_d[i*DataWidth +: DataWidth] =
                bank_rdata_i[i*DataWidth +: DataWidth];
            end
          end
          got_d = got_q | rsp_hit;
          if (pending_q == '0 && got_d == '1) begin
            state_d = RESP;
          end
        end else if (pending_d == '0) begin
          // Writes are posted: done once every enabled bank accepted.
          state_d = IDLE;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      pending_q <= '0;
      got_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      pending_q <= pending_d;
      got_q     <= got_d;
      rdata_q   <= rdata_d;
    end
  end

  assign req_ready_o      = (state_q == IDLE);
  assign resp_valid_o     = (state_q == RESP);
  assign resp_rdata_o     = rdata_q;
  assign bank_req_valid_o = pending_q;
  assign bank_addr_o      = {NumWords{addr_q}};
  assign bank_wen_o       = {NumWords{wen_q}};
  assign bank_wdata_o     = wdata_q;
  assign bank_be_o        = be_q;

`ifdef MEMPOOL_DMA_SPLIT_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where some bank holds a request unaccepted.
  always_comb begin
    stall_d = stall_q;
    if (|(pending_q & ~bank_req_ready_i) && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_mempool_dma_bank_splitter.sv
// Directed bench for mempool_dma_bank_splitter: reads, staggered reads,
// partial/empty writes, response backpressure and mid-issue reset.
module tb_mempool_dma_bank_splitter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 8;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [AW-1:0]     req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*DW/8-1:0] req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [N*DW-1:0]   resp_rdata;
  logic [N-1:0]      bank_req_valid;
  logic [N-1:0]      bank_req_ready;
  logic [N*AW-1:0]   bank_addr;
  logic [N-1:0]      bank_wen;
  logic [N*DW-1:0]   bank_wdata;
  logic [N*DW/8-1:0] bank_be;
  logic [N-1:0]      bank_resp_valid;
  logic [N*DW-1:0]   bank_rdata;
  logic [31:0]       stall_cycles;

  int checks = 0;
  int errors = 0;

  mempool_dma_bank_splitter #(
    .NumWords (N),
    .DataWidth(DW),
    .AddrWidth(AW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_wen_i        (req_wen),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .req_be_i         (req_be),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_rdata_o     (resp_rdata),
    .bank_req_valid_o (bank_req_valid),
    .bank_req_ready_i (bank_req_ready),
    .bank_addr_o      (bank_addr),
    .bank_wen_o       (bank_wen),
    .bank_wdata_o     (bank_wdata),
    .bank_be_o        (bank_be),
    .bank_resp_valid_i(bank_resp_valid),
    .bank_rdata_i     (bank_rdata),
    .stall_cycles_o   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [N*DW-1:0] rd1, rd2, rd3, wd;

  initial begin
    rd1 = 128'h44444444_33333333_22222222_11111111;
    rd2 = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    rd3 = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    wd  = 128'hAAAA0003_BBBB0002_CCCC0001_DDDD0000;

    rst             = 1'b1;
    req_valid       = 1'b0;
    req_wen         = 1'b0;
    req_addr        = '0;
    req_wdata       = '0;
    req_be          = '0;
    resp_ready      = 1'b1;
    bank_req_ready  = '0;
    bank_resp_valid = '0;
    bank_rdata      = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_req_ready", 128'(req_ready), 128'd1);
    chk("rst_resp_valid", 128'(resp_valid), 128'd0);
    chk("rst_bank_valid", 128'(bank_req_valid), 128'd0);
    chk("rst_rdata", resp_rdata, 128'd0);
    chk("rst_stall", 128'(stall_cycles), 128'd0);

    // Read, all banks ready.
    req_valid      = 1'b1;
    req_wen        = 1'b0;
    req_addr       = 8'h2A;
    bank_req_ready = 4'hF;
    tick();
    req_valid = 1'b0;
    chk("rd_bank_valid", 128'(bank_req_valid), 128'hF);
    chk("rd_bank_addr", 128'(bank_addr), 128'h2A2A2A2A);
    chk("rd_bank_wen", 128'(bank_wen), 128'h0);
    chk("rd_req_ready", 128'(req_ready), 128'd0);
    tick();
    bank_resp_valid = 4'hF;
    bank_rdata      = rd1;
    chk("rd_t2_valid", 128'(bank_req_valid), 128'h0);
    chk("rd_t2_resp", 128'(resp_valid), 128'd0);
    tick();
    bank_resp_valid = '0;
    chk("rd_t3_resp", 128'(resp_valid), 128'd1);
    chk("rd_t3_data", resp_rdata, rd1);
    tick();
    chk("rd_done_ready", 128'(req_ready), 128'd1);
    chk("rd_done_resp", 128'(resp_valid), 128'd0);

    // Staggered read: bank 2 stalls 5 cycles, responses 3,0,1,2.
    req_valid      = 1'b1;
    req_addr       = 8'h55;
    bank_req_ready = 4'b1011;
    bank_rdata     = rd2;
    tick();
    req_valid = 1'b0;
    chk("stg_c1_valid", 128'(bank_req_valid), 128'hF);
    tick();
    chk("stg_c2_valid", 128'(bank_req_valid), 128'h4);
    bank_resp_valid = 4'b1000;
    tick();
    chk("stg_c3_valid", 128'(bank_req_valid), 128'h4);
    chk("stg_c3_addr", 128'(bank_addr), 128'h55555555);
    chk("stg_c3_resp", 128'(resp_valid), 128'd0);
    bank_resp_valid = 4'b0001;
    tick();
    chk("stg_c4_valid", 128'(bank_req_valid), 128'h4);
    bank_resp_valid = 4'b0010;
    tick();
    bank_resp_valid = '0;
    chk("stg_c5_valid", 128'(bank_req_valid), 128'h4);
    chk("stg_c5_resp", 128'(resp_valid), 128'd0);
    bank_req_ready = 4'hF;
    tick();
    chk("stg_c6_valid", 128'(bank_req_valid), 128'h0);
    chk("stg_c6_resp", 128'(resp_valid), 128'd0);
    bank_resp_valid = 4'b0100;
    tick();
    bank_resp_valid = '0;
    chk("stg_resp", 128'(resp_valid), 128'd1);
    chk("stg_data", resp_rdata, rd2);
    tick();
    chk("stg_done", 128'(req_ready), 128'd1);

    // Partial write: words 0 and 3 enabled.
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 8'h13;
    req_wdata = wd;
    req_be    = 16'hF00F;
    tick();
    req_valid = 1'b0;
    chk("wr_bank_valid", 128'(bank_req_valid), 128'h9);
    chk("wr_bank_wen", 128'(bank_wen), 128'hF);
    chk("wr_bank_wdata", bank_wdata, wd);
    chk("wr_bank_be", 128'(bank_be), 128'hF00F);
    chk("wr_bank_addr", 128'(bank_addr), 128'h13131313);
    chk("wr_t1_ready", 128'(req_ready), 128'd0);
    tick();
    chk("wr_t2_ready", 128'(req_ready), 128'd1);
    chk("wr_t2_valid", 128'(bank_req_valid), 128'h0);
    chk("wr_t2_resp", 128'(resp_valid), 128'd0);

    // All-zero byte-enable write.
    req_valid = 1'b1;
    req_be    = 16'h0000;
    tick();
    req_valid = 1'b0;
    chk("wz_valid", 128'(bank_req_valid), 128'h0);
    chk("wz_ready", 128'(req_ready), 128'd0);
    tick();
    chk("wz_back_ready", 128'(req_ready), 128'd1);
    chk("wz_resp", 128'(resp_valid), 128'd0);

    // Response backpressure with a second request held valid.
    req_valid  = 1'b1;
    req_wen    = 1'b0;
    req_addr   = 8'h77;
    resp_ready = 1'b0;
    bank_rdata = rd3;
    tick();
    chk("bp_valid", 128'(bank_req_valid), 128'hF);
    tick();
    bank_resp_valid = 4'hF;
    tick();
    bank_resp_valid = '0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_resp", 128'(resp_valid), 128'd1);
      chk("bp_data", resp_rdata, rd3);
      chk("bp_ready", 128'(req_ready), 128'd0);
      if (i < 3) tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_idle_ready", 128'(req_ready), 128'd1);
    chk("bp_idle_resp", 128'(resp_valid), 128'd0);
    bank_req_ready = 4'b0011;
    tick();
    req_valid = 1'b0;
    chk("bp_next_valid", 128'(bank_req_valid), 128'hF);
    tick();

    // Reset with banks 2 and 3 still pending.
    chk("rst_mid_pend", 128'(bank_req_valid), 128'hC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", 128'(bank_req_valid), 128'h0);
    chk("rst_mid_ready", 128'(req_ready), 128'd1);
    bank_resp_valid = 4'b1100;
    bank_rdata      = rd1;
    tick();
    bank_resp_valid = '0;
    tick();
    chk("late_rdata", resp_rdata, 128'd0);
    chk("late_resp", 128'(resp_valid), 128'd0);
    chk("late_ready", 128'(req_ready), 128'd1);
    chk("late_valid", 128'(bank_req_valid), 128'h0);

`ifdef MEMPOOL_DMA_SPLIT_STALL_CNT_EN
    // Bank 0 stalled for 7 cycles.
    chk("sc_start", 128'(stall_cycles), 128'd0);
    req_valid      = 1'b1;
    req_wen        = 1'b0;
    bank_req_ready = 4'b1110;
    bank_rdata     = rd2;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("sc_seven", 128'(stall_cycles), 128'd7);
    bank_req_ready = 4'hF;
    tick();
    bank_resp_valid = 4'hF;
    tick();
    bank_resp_valid = '0;
    chk("sc_resp", 128'(resp_valid), 128'd1);
    tick();
    chk("sc_hold", 128'(stall_cycles), 128'd7);
`else
    chk("sc_tied", 128'(stall_cycles), 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
